// File: rtl/lsu_ram_master_if.sv
// Request, response and SRAM signal group of the load/store RAM initiator.
interface lsu_ram_master_if #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          ram_cs;
    logic          ram_we;
    logic [MW-1:0] ram_wem;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    // Initiator side: the lsu_ram_master block itself.
    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output ram_cs, ram_we, ram_wem, ram_addr, ram_din,
        input  ram_dout
    );

    // Surroundings: LSU stage plus the SRAM.
    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  ram_cs, ram_we, ram_wem, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/lsu_ram_master.sv
// Single-outstanding load/store initiator for the single-port data SRAM.
// Misaligned/illegal requests are answered with an error and never reach the RAM.
module lsu_ram_master #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic            clk,
    input  logic            rst,
    lsu_ram_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACC, RDAT, RESP} state_t;

    state_t        state, state_nxt;
    logic          r_we, r_uns;
    logic [1:0]    r_size;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic          accept;
    logic          mis;
    logic [DW-1:0] lane;
    logic [DW-1:0] ext;

    assign accept        = bus.req_valid && bus.req_ready;
    assign mis           = (bus.req_size == 2'd3)
                        || (bus.req_size == 2'd1 && bus.req_addr[0])
                        || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = !rst;
                if (bus.req_valid && !rst) begin
                    state_nxt = mis ? RESP : ACC;
                end
            end
            ACC:  state_nxt = r_we ? RESP : RDAT;
            RDAT: state_nxt = RESP;
            RESP: begin
                bus.rsp_valid = !rst;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request capture and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                r_we    <= bus.req_we;
                r_uns   <= bus.req_unsigned;
                r_size  <= bus.req_size;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_err   <= mis;
                r_rdata <= '0;
            end else if (state == RDAT) begin
                r_rdata <= ext;
            end
        end
    end

    // Lane select and sign/zero extension of the read word.
    always_comb begin
        lane = bus.ram_dout >> {r_addr[1:0], 3'b000};
        case (r_size)
            2'd0:    ext = r_uns ? {{(DW-8){1'b0}}, lane[7:0]}
                                 : {{(DW-8){lane[7]}}, lane[7:0]};
            2'd1:    ext = r_uns ? {{(DW-16){1'b0}}, lane[15:0]}
                                 : {{(DW-16){lane[15]}}, lane[15:0]};
            default: ext = bus.ram_dout;
        endcase
    end

    // RAM strobes decoded from state; gated by rst so a reset during ACC writes nothing.
    always_comb begin
        bus.ram_cs   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_wem  = '0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (state == ACC && !rst) begin
            bus.ram_cs   = 1'b1;
            bus.ram_addr = {r_addr[AW-1:2], 2'b00};
            if (r_we) begin
                bus.ram_we = 1'b1;
                case (r_size)
                    2'd0: begin
                        bus.ram_wem = MW'(1) << r_addr[1:0];
                        bus.ram_din = {(DW/8){r_wdata[7:0]}};
                    end
                    2'd1: begin
                        bus.ram_wem = MW'(3) << r_addr[1:0];
                        bus.ram_din = {(DW/16){r_wdata[15:0]}};
                    end
                    default: begin
                        bus.ram_wem = '1;
                        bus.ram_din = r_wdata;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lsu_ram_master.sv
// Self-checking bench for lsu_ram_master: directed vector table, multi-cycle
// corner sequences, and random traffic against a byte-addressed memory model.
module tb_lsu_ram_master;
    logic clk = 1'b0;
    logic rst = 1'b1;

    lsu_ram_master_if #(.AW(32), .DW(32), .MW(4)) bus ();

    lsu_ram_master #(.AW(32), .DW(32), .MW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous, read data appears the cycle after the access.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.ram_we && bus.ram_wem[k]) begin
                    mem[bus.ram_addr[7:2]][8*k +: 8] <= bus.ram_din[8*k +: 8];
                end
            end
            bus.ram_dout <= mem[bus.ram_addr[7:2]];
        end
    end

    // Reference memory, one byte per entry.
    logic [7:0] gmem [0:255];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [7:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] a, input logic [1:0] sz, input logic uns);
        int unsigned n = 1 << sz;
        logic [31:0] v = '0;
        for (int unsigned k = 0; k < n; k++) v = v | (32'(gmem[int'(a) + k]) << (8 * k));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input logic [7:0] a, input logic [1:0] sz, input logic [31:0] wd);
        int unsigned n = 1 << sz;
        for (int unsigned k = 0; k < n; k++) gmem[int'(a) + k] = wd[8*k +: 8];
    endtask

    // Observations from the most recent run_op.
    logic [31:0] o_rdata, o_din, o_addr;
    logic        o_err, o_we;
    logic [3:0]  o_wem;
    int          o_lat, o_cs;

    // One complete transaction; hold = cycles of rsp_ready=0 after rsp_valid.
    task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input int hold);
        int n = 0;
        @(negedge clk);
        bus.req_we = we; bus.req_size = sz; bus.req_unsigned = uns;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        o_lat = 1; o_cs = 0; o_wem = '0; o_din = '0; o_addr = '0; o_we = 1'b0;
        forever begin
            if (bus.ram_cs) begin
                o_cs++; o_wem = bus.ram_wem; o_din = bus.ram_din;
                o_addr = bus.ram_addr; o_we = bus.ram_we;
            end
            if (bus.rsp_valid || o_lat >= 10) break;
            @(negedge clk);
            o_lat++;
        end
        chk("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
        o_rdata = bus.rsp_rdata;
        o_err   = bus.rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, o_rdata);
            chk("hold_err", 32'(bus.rsp_err), 32'(o_err));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_ram_cs"}, 32'(bus.ram_cs), 32'd0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_ram_wem"}, 32'(bus.ram_wem), 32'd0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 32'd0);
        chk({tag, "_ram_din"}, bus.ram_din, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_wem;
        logic [31:0] exp_din;
    } vec_t;

    vec_t vt [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp, word30, bp_exp;
        logic [1:0]  sz;
        logic [7:0]  a;
        logic        we, uns, e;
        int          nbad;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'hF,    32'hDEADBEEF};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'h0,    32'h0};
        vt[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'hABCD0080, 32'h0,        1'b0, 2, 4'b1000, 32'h80808080};
        vt[3]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3, 4'h0,    32'h0};
        vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0, 3, 4'h0,    32'h0};
        vt[5]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 32'h0,        1'b0, 2, 4'b1100, 32'h12341234};
        vt[6]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 32'h0,        1'b0, 2, 4'b1100, 32'h80018001};
        vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0,    32'h0};
        vt[8]  = '{1'b0, 2'd1, 1'b0, 32'h21, 32'h0,        32'h0,        1'b1, 1, 4'h0,    32'h0};
        vt[9]  = '{1'b1, 2'd2, 1'b0, 32'h22, 32'h55555555, 32'h0,        1'b1, 1, 4'h0,    32'h0};
        vt[10] = '{1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 4'h0,    32'h0};
        vt[11] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h80010000, 1'b0, 3, 4'h0,    32'h0};

        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) gmem[i] = '0;
        bus.ram_dout = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk_quiet("rst");
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, 0);
            chk($sformatf("v%0d_rdata", i), o_rdata, vt[i].exp_rdata);
            chk($sformatf("v%0d_err", i), 32'(o_err), 32'(vt[i].exp_err));
            chk($sformatf("v%0d_lat", i), 32'(o_lat), 32'(vt[i].exp_lat));
            chk($sformatf("v%0d_cs_cycles", i), 32'(o_cs), vt[i].exp_err ? 32'd0 : 32'd1);
            if (!vt[i].exp_err) begin
                chk($sformatf("v%0d_wem", i), 32'(o_wem), 32'(vt[i].exp_wem));
                chk($sformatf("v%0d_addr", i), o_addr, vt[i].addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d_we", i), 32'(o_we), 32'(vt[i].we));
                if (vt[i].we) chk($sformatf("v%0d_din", i), o_din, vt[i].exp_din);
            end
            if (vt[i].we && !vt[i].exp_err) model_store(vt[i].addr[7:0], vt[i].size, vt[i].wdata);
        end

        // Backpressure with a pending request behind the response.
        bp_exp = model_load(8'h10, 2'd2, 1'b0);
        @(negedge clk);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h10; bus.req_valid = 1'b1;
        chk("bp_accept_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int n = 0; n < 10 && !bus.rsp_valid; n++) @(negedge clk);
        chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rdata", bus.rsp_rdata, bp_exp);
        bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_addr = 32'h11;
        bus.req_wdata = 32'h0000005A; bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold_rdata", bus.rsp_rdata, bp_exp);
            chk("bp_hold_err", 32'(bus.rsp_err), 32'd0);
            chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_handshake_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("bp_after_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_after_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("bp_next_cs", 32'(bus.ram_cs), 32'd1);
        chk("bp_next_wem", 32'(bus.ram_wem), 32'b0010);
        for (int n = 0; n < 10 && !bus.rsp_valid; n++) @(negedge clk);
        chk("bp_next_rsp", 32'(bus.rsp_valid), 32'd1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_store(8'h11, 2'd0, 32'h0000005A);

        // Reset asserted during the ACC cycle of a store.
        word30 = model_load(8'h30, 2'd2, 1'b0);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_addr = 32'h30;
        bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        chk("rst_mid_accept", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid_acc_cs", 32'(bus.ram_cs), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_gated_cs", 32'(bus.ram_cs), 32'd0);
        chk("rst_mid_gated_we", 32'(bus.ram_we), 32'd0);
        @(negedge clk);
        chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
        chk_quiet("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rst_mid_mem_unchanged", mem[12], word30);
        run_op(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0);
        chk("rst_mid_next_rdata", o_rdata, word30);
        chk("rst_mid_next_lat", 32'(o_lat), 32'd3);

        // Random traffic against the byte-level model.
        for (int i = 0; i < 150; i++) begin
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 8'($urandom_range(0, 255));
            e   = model_err(sz, a);
            exp = (we || e) ? 32'h0 : model_load(a, sz, uns);
            run_op(we, sz, uns, {24'h0, a}, $urandom, int'($urandom_range(0, 3)));
            chk("rnd_rdata", o_rdata, exp);
            chk("rnd_err", 32'(o_err), 32'(e));
            chk("rnd_lat", 32'(o_lat), e ? 32'd1 : (we ? 32'd2 : 32'd3));
            chk("rnd_cs_cycles", 32'(o_cs), e ? 32'd0 : 32'd1);
            if (we && !e) begin
                chk("rnd_wem", 32'(o_wem),
                    32'((((32'd1 << (32'd1 << sz)) - 32'd1) << a[1:0]) & 32'hF));
                model_store(a, sz, bus.req_wdata);
            end
        end

        nbad = 0;
        for (int w = 0; w < 64; w++) begin
            if (mem[w] !== {gmem[4*w+3], gmem[4*w+2], gmem[4*w+1], gmem[4*w]}) nbad++;
        end
        chk("mem_image_bad_words", 32'(nbad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_ram_master.md
# lsu_ram_master

Load/store initiator for the single-port data SRAM: accepts one load or store request at a time from the execute/LSU stage over a valid/ready handshake. It drives the RAM chip-select, write-enable, byte-lane mask, address and write data. It captures the RAM read data one cycle after the access, then aligns it and sign- or zero-extends it. It returns a registered response, with misaligned or illegal requests flagged as errors and never reaching the RAM.

## Interface
- AW, 32, address width in bits (byte address).
- DW, 32, data width; only 32 is supported.
- MW, 4, byte-lane count; must equal DW/8.

- clk  input  1  clock, all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
- req_addr  input  AW  byte address
- req_wdata  input  DW  store data, right-aligned (LSBs)
- rsp_valid  output  1  response present, held until rsp_ready
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready
- rsp_rdata  output  DW  extended load data; 0 for stores and errors
- rsp_err  output  1  misaligned or illegal-size request
- ram_cs  output  1  RAM chip select
- ram_we  output  1  RAM write enable
- ram_wem  output  MW  RAM byte-lane write mask
- ram_addr  output  AW  RAM byte address, bits [1:0] forced to 0
- ram_din  output  DW  RAM write data, lane-replicated
- ram_dout  input  DW  RAM read data, valid the cycle after a read access

## Operation
- FSM states and transitions:
  - IDLE: req_ready=1. On accept, request fields are registered. Misaligned or illegal requests go to RESP with err=1; all others go to ACC.
  - ACC: drives the RAM for exactly one cycle. Stores go to RESP. Loads go to RDAT.
  - RDAT: ram_dout is sampled, lane-selected and extended into the rsp_rdata register. Next state is RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- req_ready is 1 only in IDLE (and not during rst). There is only one outstanding request and no pipelining.
- Misalignment rules: half with addr[0]=1; word with addr[1:0]≠0; any request with size=3.
- Store lanes, with o = addr[1:0]:
  - byte: wem = 1<<o, din = {4{wdata[7:0]}}
  - half: wem = 4'b0011<<o, din = {2{wdata[15:0]}}
  - word: wem = 4'hF, din = wdata
- Loads: ram_we=0, ram_wem=0.
  - byte takes dout[8o+7:8o].
  - half takes dout[8o+15:8o].
  - The result is sign- or zero-extended per the registered req_unsigned.
- RAM outputs (cs, we, wem, addr, din) are decoded from state and registered fields. They are all-zero outside ACC and forced to zero while rst=1.
- Errors: rsp_err=1, rsp_rdata=0, and no RAM cycle occurs.
- Stores: rsp_err=0, rsp_rdata=0.

## Timing
- Reset values: state=IDLE, req_ready=0 during rst, 1 on the first cycle after rst. rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cs=0, ram_we=0, ram_wem=0, ram_addr=0, ram_din=0.
- Load, accepted at T0: ram_cs=1 at T1, ram_dout sampled at T2, rsp_valid=1 from T3. The earliest next accept is T4 when rsp_ready=1 at T3.
- Store, accepted at T0: ram_cs=ram_we=1 at T1, rsp_valid=1 from T2.
- Error, accepted at T0: rsp_valid=1, rsp_err=1 at T1.
- Backpressure: RESP holds rsp_valid, rsp_rdata and rsp_err stable for any number of cycles. Request inputs are ignored outside IDLE.
- rst at any state returns to IDLE on that edge and drops any pending response.
  - Because RAM outputs are gated by rst, a store whose ACC cycle coincides with rst is not written.
  - A load interrupted in RDAT produces no response.
- Simultaneous rsp handshake and new req_valid in RESP: the request is not accepted that cycle (req_ready=0). It is accepted in IDLE on the next cycle.

## Test plan
- Word store then load: store addr=0x10, wdata=0xDEADBEEF gives ram_wem=4'hF, ram_addr=0x10 at T1. A load of word 0x10 gives rsp_rdata=0xDEADBEEF at T3, rsp_err=0.
- Byte lanes and extension:
  - Store byte 0x80 to 0x13 gives wem=4'b1000, din=0x80808080.
  - Signed byte load from 0x13 gives 0xFFFFFF80.
  - Unsigned byte load from 0x13 gives 0x00000080.
- Half store 0x1234 to 0x22 gives wem=4'b1100, din=0x12341234. A signed half load from 0x22 over a word of 0x8001xxxx gives 0xFFFF8001.
- Errors:
  - Half at 0x21, word at 0x22, and size=3 each give rsp_err=1 at T1 with rsp_rdata=0.
  - ram_cs stays 0 throughout.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load. rsp_valid and rsp_rdata stay stable, req_ready=0, and a pending req_valid is accepted exactly one cycle after the rsp handshake.
- Reset mid-operation: assert rst during ACC of a store to 0x30. The memory word at 0x30 is unchanged, all outputs reach their reset values, and the next request completes normally.
